// File: rtl/mult_issue.sv
// mult_issue: queues operand pairs and issues them one at a time to a fixed-latency multiplier
module mult_issue #(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 40
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_mlier,
   input  logic [31:0] in_mcand,
   output logic [31:0] mult_mlier,
   output logic [31:0] mult_mcand,
   output logic        mult_start,
   input  logic [63:0] mult_prodt,
   input  logic        mult_valid,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] out_prodt,
   output logic        busy,
   output logic        timeout_err
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
   typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;
   state_t state, state_nx;
   logic [63:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0] count;
   logic [CW-1:0] cycles;
   logic mv_prev, push, pop, capture, expire;
   assign in_ready = reset && count != FULL;
   assign push = in_valid && in_ready;
   assign pop = state == IDLE && count != '0 && !out_valid;
   assign capture = state == ISSUE && mult_valid && !mv_prev;
   assign expire = state == ISSUE && !capture && cycles == LAST;
   assign busy = state != IDLE || count != '0;
   // operand storage; the pointers alone define which entries are live
   always_ff @(posedge clock)
      if (push) mem[wr_ptr] <= {in_mlier, in_mcand};
   // state register
   always_ff @(posedge clock)
      state <= !reset ? IDLE : state_nx;
   // IDLE issues on pop, ISSUE ends on capture or expiry, GAP is one re-arm clock
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = pop ? ISSUE : IDLE;
         ISSUE:   state_nx = (capture || expire) ? GAP : ISSUE;
         default: state_nx = IDLE;
      endcase
   end
   // FIFO bookkeeping, operand launch, cycle counter, result capture and error flag
   always_ff @(posedge clock) begin
      if (!reset) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         cycles      <= '0;
         mv_prev     <= 1'b0;
         mult_start  <= 1'b0;
         mult_mlier  <= '0;
         mult_mcand  <= '0;
         out_valid   <= 1'b0;
         out_prodt   <= '0;
         timeout_err <= 1'b0;
      end else begin
         mv_prev <= mult_valid;
         count   <= count + (AW + 1)'(push) - (AW + 1)'(pop);
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop) begin
            rd_ptr                   <= rd_ptr + AW'(1);
            {mult_mlier, mult_mcand} <= mem[rd_ptr];
            mult_start               <= 1'b1;
            cycles                   <= '0;
         end else if (state == ISSUE) cycles <= cycles + CW'(1);
         if (capture || expire) mult_start <= 1'b0;
         if (capture) begin
            out_prodt <= mult_prodt;
            out_valid <= 1'b1;
         end else if (out_valid && out_ready) out_valid <= 1'b0;
         if (expire) timeout_err <= 1'b1;
      end
   end
endmodule

// File: tb/tb_mult_issue.sv
// tb_mult_issue: directed and randomized checks of mult_issue against a queue-based reference
module tb_mult_issue;
   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_mlier = '0;
   logic [31:0] in_mcand = '0;
   logic [31:0] mult_mlier, mult_mcand;
   logic        mult_start;
   logic [63:0] mult_prodt;
   logic        mult_valid;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [63:0] out_prodt;
   logic        busy, timeout_err;
   int          passes = 0;
   int          total = 0;
   int          lat = 3;
   int          mcnt = 0;
   logic        mult_en = 1'b1;
   logic        force_mv = 1'b0;
   logic        accepted = 1'b0;
   logic [63:0] cur_op = '0;
   logic [63:0] exp_q[$];
   logic [63:0] op_q[$];

   mult_issue dut (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_mlier(in_mlier), .in_mcand(in_mcand), .mult_mlier(mult_mlier),
      .mult_mcand(mult_mcand), .mult_start(mult_start), .mult_prodt(mult_prodt),
      .mult_valid(mult_valid), .out_valid(out_valid), .out_ready(out_ready),
      .out_prodt(out_prodt), .busy(busy), .timeout_err(timeout_err)
   );

   always #5 clock = ~clock;

   function automatic logic [63:0] smul(input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] x, y;
      x = {{32{a[31]}}, a};
      y = {{32{b[31]}}, b};
      return x * y;
   endfunction

   // multiplier model: result level appears lat clocks after start and holds while start is high
   always @(posedge clock) mcnt <= mult_start ? mcnt + 1 : 0;
   assign mult_valid = force_mv || (mult_en && mult_start && mcnt >= lat);
   assign mult_prodt = force_mv ? 64'hBADC_0FFE_E0DD_F00D : smul(mult_mlier, mult_mcand);

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0:       return 32'h8000_0000;
         1:       return 32'h7FFF_FFFF;
         2:       return 32'hFFFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
      total++;
      assert (got === want) passes++;
      else $error("FAIL %s: observed %h expected %h", tag, got, want);
   endtask

   task automatic step();
      logic hs, ov_b, st_b;
      logic [63:0] prod_b;
      hs = reset && out_valid && out_ready;
      ov_b = out_valid;
      st_b = mult_start;
      prod_b = out_prodt;
      accepted = reset && in_valid && in_ready;
      if (accepted) begin
         exp_q.push_back(smul(in_mlier, in_mcand));
         op_q.push_back({in_mlier, in_mcand});
      end
      if (!reset) begin
         exp_q.delete();
         op_q.delete();
      end
      @(posedge clock);
      #1;
      if (hs) begin
         chk("out_expected", 64'(exp_q.size() != 0), 64'd1);
         if (exp_q.size() != 0) chk("out_prodt_order", prod_b, exp_q.pop_front());
      end
      if (ov_b && !hs && out_valid) chk("out_prodt_hold", out_prodt, prod_b);
      if (mult_start && !st_b) begin
         chk("issue_expected", 64'(op_q.size() != 0), 64'd1);
         if (op_q.size() != 0) begin
            cur_op = op_q.pop_front();
            chk("issue_ops", {mult_mlier, mult_mcand}, cur_op);
         end
      end else if (mult_start && st_b) chk("issue_stable", {mult_mlier, mult_mcand}, cur_op);
   endtask

   task automatic push(input logic [31:0] a, input logic [31:0] b);
      in_mlier = a;
      in_mcand = b;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
   endtask

   task automatic wait_ov(input string tag, input int budget);
      int n = 0;
      while (!out_valid && n < budget) begin
         step();
         n++;
      end
      chk(tag, 64'(out_valid), 64'd1);
   endtask

   task automatic drain(input string tag, input int budget);
      int n = 0;
      out_ready = 1'b1;
      while ((exp_q.size() != 0 || busy || out_valid) && n < budget) begin
         step();
         n++;
      end
      chk(tag, 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      logic [31:0] a0, b0;
      int n;
      step();
      step();
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_start", 64'(mult_start), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_prodt", out_prodt, 64'd0);
      chk("rst_timeout", 64'(timeout_err), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_ops", {mult_mlier, mult_mcand}, 64'd0);
      reset = 1'b1;
      step();
      chk("rel_in_ready", 64'(in_ready), 64'd1);
      // 3 x 5: start rises one clock after the push, result valid for exactly one clock
      push(32'd3, 32'd5);
      chk("t1_busy", 64'(busy), 64'd1);
      chk("t1_no_bypass", 64'(mult_start), 64'd0);
      step();
      chk("t1_start", 64'(mult_start), 64'd1);
      wait_ov("t1_wait", 20);
      chk("t1_prodt", out_prodt, 64'h0000_0000_0000_000F);
      step();
      chk("t1_one_clock", 64'(out_valid), 64'd0);
      drain("t1_drain", 20);
      // -2 x 7 keeps its sign across the full 64 bits
      push(32'hFFFF_FFFE, 32'd7);
      wait_ov("t2_wait", 20);
      chk("t2_prodt", out_prodt, 64'hFFFF_FFFF_FFFF_FFF2);
      drain("t2_drain", 20);
      // result and timeout land on the same edge: the result wins
      lat = 39;
      push(32'd11, 32'd13);
      wait_ov("same_edge_wait", 100);
      chk("same_edge_prodt", out_prodt, 64'd143);
      chk("same_edge_no_err", 64'(timeout_err), 64'd0);
      drain("same_edge_drain", 20);
      lat = 3;
      // backpressure: first completes, next four fill the FIFO
      out_ready = 1'b0;
      a0 = pick();
      b0 = pick();
      push(a0, b0);
      for (int i = 0; i < 4; i++) push(pick(), pick());
      wait_ov("bp_wait", 30);
      chk("bp_first", out_prodt, smul(a0, b0));
      chk("bp_full", 64'(in_ready), 64'd0);
      chk("bp_busy", 64'(busy), 64'd1);
      in_mlier = 32'd1;
      in_mcand = 32'd1;
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("bp_still_full", 64'(in_ready), 64'd0);
      end
      in_valid = 1'b0;
      drain("bp_drain", 400);
      // stray mult_valid in GAP and in IDLE is ignored
      out_ready = 1'b0;
      push(32'd4, 32'd4);
      wait_ov("gap_wait", 20);
      force_mv = 1'b1;
      step();
      force_mv = 1'b0;
      step();
      chk("gap_prodt", out_prodt, 64'd16);
      chk("gap_valid", 64'(out_valid), 64'd1);
      drain("gap_drain", 20);
      force_mv = 1'b1;
      step();
      force_mv = 1'b0;
      step();
      step();
      chk("idle_pulse", 64'(out_valid), 64'd0);
      // multiplier never answers: abandon after 40 clocks, next pair still issues
      mult_en = 1'b0;
      push(32'd9, 32'hFFFF_FFFC);
      push(32'd6, 32'd6);
      chk("to_start", 64'(mult_start), 64'd1);
      n = 0;
      while (mult_start && n < 100) begin
         step();
         n++;
      end
      mult_en = 1'b1;
      chk("to_clocks", 64'(n), 64'd40);
      chk("to_err", 64'(timeout_err), 64'd1);
      chk("to_no_out", 64'(out_valid), 64'd0);
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      wait_ov("to_next_wait", 30);
      chk("to_next_prodt", out_prodt, 64'd36);
      drain("to_drain", 30);
      chk("to_sticky", 64'(timeout_err), 64'd1);
      // reset mid-ISSUE with two pairs queued
      lat = 20;
      push(32'd2, 32'd3);
      push(32'd4, 32'd5);
      push(32'd6, 32'd7);
      chk("ra_issuing", 64'(mult_start), 64'd1);
      reset = 1'b0;
      step();
      chk("ra_start", 64'(mult_start), 64'd0);
      chk("ra_in_ready", 64'(in_ready), 64'd0);
      chk("ra_empty", 64'(busy), 64'd0);
      reset = 1'b1;
      step();
      chk("ra_rel_ready", 64'(in_ready), 64'd1);
      chk("ra_err_clear", 64'(timeout_err), 64'd0);
      for (int i = 0; i < 60; i++) step();
      chk("ra_no_result", 64'(out_valid), 64'd0);
      chk("ra_no_issue", 64'(mult_start), 64'd0);
      lat = 3;
      // random traffic with random backpressure
      for (int i = 0; i < 16; i++) begin
         lat = $urandom_range(1, 6);
         in_mlier = pick();
         in_mcand = pick();
         in_valid = 1'b1;
         n = 0;
         accepted = 1'b0;
         while (!accepted && n < 200) begin
            out_ready = 1'($urandom_range(0, 1));
            step();
            n++;
         end
         chk("rand_push", 64'(accepted), 64'd1);
         in_valid = 1'b0;
      end
      drain("rand_drain", 600);
      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end
endmodule
